irq_source_ctrl: RTL and testbench

//  Requesting end of the processor's interrupt/acknowledge interface; the accumulator core is the receiver.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_source_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_source_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int DEF_ACK_TIMEOUT = 16;

    // A single source still needs a 1-bit vector.
    function automatic int irq_id_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the eligible request vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int ID_W    = irq_id_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    // Scan downward so the last hit is the lowest index.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_source_ctrl.sv
// Edge-captured, masked, priority-arbitrated interrupt requester with ack/eoi handshake.
// Optional ack timeout enabled by defining IRQ_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | no interrupt outstanding, arbitrating eligible sources
//   ASSERT  | interrupt driven, waiting for int_ack
//   SERVICE | core servicing sel, waiting for int_eoi
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter  int NUM_SRC     = 4,
    parameter  int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    localparam int IRQ_ID_W    = irq_id_w(NUM_SRC)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_SRC-1:0]  irq_req,
    input  logic                mask_wr,
    input  logic [NUM_SRC-1:0]  mask_in,
    input  logic                int_ack,
    input  logic                int_eoi,
    output logic                interrupt,
    output logic [IRQ_ID_W-1:0] int_vector,
    output logic                busy,
    output logic                timeout_err
);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("irq_source_ctrl: NUM_SRC out of range");
    end
    if (ACK_TIMEOUT < 2 || ACK_TIMEOUT > 256) begin : g_bad_timeout
        $error("irq_source_ctrl: ACK_TIMEOUT out of range");
    end

    logic [NUM_SRC-1:0]  req_q;
    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  mask;
    logic [NUM_SRC-1:0]  edge_det;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  clr;
    logic [IRQ_ID_W-1:0] win_id;
    logic [IRQ_ID_W-1:0] sel;
    logic                win_valid;
    irq_state_t          state;

`ifdef IRQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] ack_cnt;
    logic       to_q;
    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign edge_det   = irq_req & ~req_q;
    assign eligible   = pending & mask;
    assign int_vector = sel;

    always_comb begin
        clr = '0;
        if (state == ASSERT && int_ack) clr[sel] = 1'b1;
    end

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .eligible (eligible),
        .id       (win_id),
        .valid    (win_valid)
    );

    // A fresh edge in the ack cycle must survive the clear, so set wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q   <= '0;
            pending <= '0;
            mask    <= '1;
        end else begin
            req_q   <= irq_req;
            pending <= (pending & ~clr) | edge_det;
            if (mask_wr) mask <= mask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            sel       <= '0;
            interrupt <= 1'b0;
            busy      <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
            ack_cnt   <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
`ifdef IRQ_TIMEOUT_EN
            to_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        sel       <= win_id;
                        interrupt <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ASSERT;
`ifdef IRQ_TIMEOUT_EN
                        ack_cnt   <= '0;
`endif
                    end
                end
                ASSERT: begin
                    if (int_ack) begin
                        interrupt <= 1'b0;
                        state     <= SERVICE;
`ifdef IRQ_TIMEOUT_EN
                    end else if (ack_cnt == TO_LAST) begin
                        interrupt <= 1'b0;
                        busy      <= 1'b0;
                        to_q      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        ack_cnt   <= ack_cnt + 8'd1;
`endif
                    end
                end
                SERVICE: begin
                    if (int_eoi) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    interrupt <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed self-checking bench for irq_source_ctrl (NUM_SRC=4, ACK_TIMEOUT=16).
module tb_irq_source_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] irq_req;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       int_eoi;
    logic       interrupt;
    logic [1:0] int_vector;
    logic       busy;
    logic       timeout_err;

    int nvec = 0;
    int nerr = 0;

    irq_source_ctrl #(.NUM_SRC(4), .ACK_TIMEOUT(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .irq_req     (irq_req),
        .mask_wr     (mask_wr),
        .mask_in     (mask_in),
        .int_ack     (int_ack),
        .int_eoi     (int_eoi),
        .interrupt   (interrupt),
        .int_vector  (int_vector),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_int, input logic [1:0] e_vec,
                              input logic e_busy, input logic e_to);
        nvec++;
        assert (interrupt === e_int) else begin
            nerr++;
            $error("FAIL %s interrupt: observed %0h expected %0h", tag, interrupt, e_int);
        end
        nvec++;
        assert (int_vector === e_vec) else begin
            nerr++;
            $error("FAIL %s int_vector: observed %0h expected %0h", tag, int_vector, e_vec);
        end
        nvec++;
        assert (busy === e_busy) else begin
            nerr++;
            $error("FAIL %s busy: observed %0h expected %0h", tag, busy, e_busy);
        end
        nvec++;
        assert (timeout_err === e_to) else begin
            nerr++;
            $error("FAIL %s timeout_err: observed %0h expected %0h", tag, timeout_err, e_to);
        end
    endtask

    initial begin
        resetn  = 1'b0;
        irq_req = 4'b1111;
        mask_wr = 1'b0;
        mask_in = 4'b0000;
        int_ack = 1'b0;
        int_eoi = 1'b0;

        // 1 reset with all lines high
        tick(); tick();
        expect_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        irq_req = 4'b0000;
        tick();
        resetn = 1'b1;
        tick(); tick(); tick();
        expect_out("post_reset_quiet", 1'b0, 2'd0, 1'b0, 1'b0);

        // 2 single request on line 2
        irq_req = 4'b0100;
        tick();
        expect_out("single_e0", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("single_e1", 1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        expect_out("single_wait_ack", 1'b1, 2'd2, 1'b1, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        expect_out("single_ack", 1'b0, 2'd2, 1'b1, 1'b0);
        tick();
        expect_out("single_service", 1'b0, 2'd2, 1'b1, 1'b0);
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        expect_out("single_eoi", 1'b0, 2'd2, 1'b0, 1'b0);
        tick(); tick();
        expect_out("held_line_no_rereq", 1'b0, 2'd2, 1'b0, 1'b0);
        irq_req = 4'b0000;
        tick();

        // 3 priority: lines 3 and 1 together, then line 0 arrives during ASSERT of 3
        irq_req = 4'b1010;
        tick(); tick();
        expect_out("prio_first", 1'b1, 2'd1, 1'b1, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        expect_out("prio_eoi1", 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        expect_out("prio_second", 1'b1, 2'd3, 1'b1, 1'b0);
        irq_req = 4'b1011;
        tick();
        expect_out("prio_frozen", 1'b1, 2'd3, 1'b1, 1'b0);
        irq_req = 4'b0000;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        expect_out("prio_eoi3", 1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        expect_out("prio_third", 1'b1, 2'd0, 1'b1, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        expect_out("prio_done", 1'b0, 2'd0, 1'b0, 1'b0);

        // 4 masking, then ack+eoi together in ASSERT
        mask_wr = 1'b1;
        mask_in = 4'b1110;
        tick();
        mask_wr = 1'b0;
        irq_req = 4'b0001;
        tick(); tick(); tick();
        expect_out("masked_no_irq", 1'b0, 2'd0, 1'b0, 1'b0);
        mask_wr = 1'b1;
        mask_in = 4'b1111;
        tick();
        mask_wr = 1'b0;
        expect_out("unmask_edge", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("unmask_irq", 1'b1, 2'd0, 1'b1, 1'b0);
        int_ack = 1'b1;
        int_eoi = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b0;
        expect_out("ack_eoi_same", 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("eoi_dropped", 1'b0, 2'd0, 1'b1, 1'b0);
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        expect_out("mask_eoi", 1'b0, 2'd0, 1'b0, 1'b0);
        irq_req = 4'b0000;
        tick();

        // 5 re-request during ack; masking sel in ASSERT keeps interrupt
        irq_req = 4'b0100;
        tick(); tick();
        expect_out("rereq_first", 1'b1, 2'd2, 1'b1, 1'b0);
        irq_req = 4'b0000;
        mask_wr = 1'b1;
        mask_in = 4'b1011;
        tick();
        mask_wr = 1'b0;
        expect_out("mask_sel_in_assert", 1'b1, 2'd2, 1'b1, 1'b0);
        int_ack = 1'b1;
        irq_req = 4'b0100;
        tick();
        int_ack = 1'b0;
        irq_req = 4'b0000;
        expect_out("rereq_ack", 1'b0, 2'd2, 1'b1, 1'b0);
        int_eoi = 1'b1;
        mask_wr = 1'b1;
        mask_in = 4'b1111;
        tick();
        int_eoi = 1'b0;
        mask_wr = 1'b0;
        expect_out("rereq_eoi", 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        expect_out("rereq_again", 1'b1, 2'd2, 1'b1, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        expect_out("rereq_done", 1'b0, 2'd2, 1'b0, 1'b0);

`ifdef IRQ_TIMEOUT_EN
        // 6 ack timeout: 16 cycles high, 1-cycle error pulse, reassert
        irq_req = 4'b1000;
        tick(); tick();
        expect_out("to_assert", 1'b1, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            expect_out("to_waiting", 1'b1, 2'd3, 1'b1, 1'b0);
        end
        tick();
        expect_out("to_fired", 1'b0, 2'd3, 1'b0, 1'b1);
        tick();
        expect_out("to_reassert", 1'b1, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        expect_out("to_ack_wins", 1'b0, 2'd3, 1'b1, 1'b0);
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        expect_out("to_done", 1'b0, 2'd3, 1'b0, 1'b0);
        irq_req = 4'b0000;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
